// File: rtl/sram_port_initiator.sv
// Valid/ready request stream to single-port SRAM strobes, with an in-order response FIFO for read data.
// Optional macro SRAM_INIT_SWEEP_EN: zero-fill the whole SRAM after reset before accepting requests.
module sram_port_initiator #(
  parameter  int unsigned NUM_WORD  = 1024,
  parameter  int unsigned NUM_BIT   = 32,
  parameter  int unsigned RSP_DEPTH = 4,
  localparam int unsigned ADDR_W    = $clog2(NUM_WORD)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               scan_en_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_BIT-1:0] req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [NUM_BIT-1:0] rsp_rdata_o,
  output logic               busy_o,
  output logic               CEB,
  output logic               WEB,
  output logic [ADDR_W-1:0]  A,
  output logic [NUM_BIT-1:0] D,
  input  logic [NUM_BIT-1:0] Q
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

`ifdef SRAM_INIT_SWEEP_EN
  localparam state_e RESET_STATE = ST_INIT;
`else
  localparam state_e RESET_STATE = ST_RUN;
`endif

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 rd_pending_q, rd_pending_d;
  logic [NUM_BIT-1:0]   mem_q [RSP_DEPTH];
  logic [NUM_BIT-1:0]   mem_d [RSP_DEPTH];
`ifdef SRAM_INIT_SWEEP_EN
  logic [ADDR_W-1:0]    sweep_q, sweep_d;
`endif

  logic credit_ok;
  logic req_fire;
  logic push;
  logic pop;

  // Occupied plus in-flight entries must leave room; a same-cycle pop is not counted as a free slot.
  always_comb begin
    credit_ok   = (SUM_W'(count_q) + SUM_W'(rd_pending_q)) < SUM_W'(RSP_DEPTH);
    req_ready_o = (state_q == ST_RUN) && !scan_en_i && !RST && (req_we_i || credit_ok);
    req_fire    = req_valid_i && req_ready_o;
    rsp_valid_o = !RST && (count_q != '0);
    rsp_rdata_o = mem_q[rd_ptr_q];
    busy_o      = RST || (state_q == ST_INIT) || scan_en_i;
    push        = rd_pending_q;
    pop         = rsp_valid_o && rsp_ready_i;
  end

  // SRAM strobes follow the accepted request directly; the init sweep takes over in INIT.
  always_comb begin
    CEB = !req_fire;
    WEB = !(req_fire && req_we_i);
    A   = req_addr_i;
    D   = req_wdata_i;
`ifdef SRAM_INIT_SWEEP_EN
    if (state_q == ST_INIT) begin
      CEB = RST || scan_en_i;
      WEB = RST || scan_en_i;
      A   = sweep_q;
      D   = '0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_d        = mem_q;
    rd_pending_d = req_fire && !req_we_i;
`ifdef SRAM_INIT_SWEEP_EN
    sweep_d      = sweep_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q] = Q;
      wr_ptr_d        = (wr_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef SRAM_INIT_SWEEP_EN
    // Scan freezes the sweep in place; the last address hands over to RUN.
    if ((state_q == ST_INIT) && !scan_en_i) begin
      sweep_d = sweep_q + ADDR_W'(1);
      if (sweep_q == ADDR_W'(NUM_WORD - 1)) begin
        state_d = ST_RUN;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RESET_STATE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_pending_q <= 1'b0;
`ifdef SRAM_INIT_SWEEP_EN
      sweep_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pending_q <= rd_pending_d;
`ifdef SRAM_INIT_SWEEP_EN
      sweep_q      <= sweep_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sram_port_initiator.sv
// Scoreboard bench for sram_port_initiator: RSP_DEPTH=4 main instance plus an RSP_DEPTH=2 throughput instance.
// Build with +define+SRAM_INIT_SWEEP_EN to also exercise the init sweep.
module tb_sram_port_initiator;

  localparam int unsigned NW = 1024;
  localparam int unsigned NB = 32;
  localparam int unsigned AW = 10;
`ifdef SRAM_INIT_SWEEP_EN
  localparam logic [NB-1:0] UNW       = 32'h0;
  localparam int            EXP_BUSY  = 1034;
  localparam logic [NB-1:0] EXP_RD5   = 32'h0;
`else
  localparam logic [NB-1:0] UNW       = 32'hA5A5_A5A5;
  localparam int            EXP_BUSY  = 0;
  localparam logic [NB-1:0] EXP_RD5   = 32'hDEAD_BEEF;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST, scan_en;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [NB-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [NB-1:0] rsp_rdata;
  logic          busy, CEB, WEB;
  logic [AW-1:0] A;
  logic [NB-1:0] D, Q;

  logic          r2_valid, r2_ready, r2_we, r2_rsp_valid, r2_rsp_ready, r2_busy, r2_ceb, r2_web;
  logic [AW-1:0] r2_addr, r2_a;
  logic [NB-1:0] r2_wdata, r2_rdata, r2_d, r2_q;

  sram_port_initiator #(.NUM_WORD(NW), .NUM_BIT(NB), .RSP_DEPTH(4)) u_dut (
    .CLK(CLK), .RST(RST), .scan_en_i(scan_en),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .busy_o(busy), .CEB(CEB), .WEB(WEB), .A(A), .D(D), .Q(Q)
  );

  sram_port_initiator #(.NUM_WORD(NW), .NUM_BIT(NB), .RSP_DEPTH(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .scan_en_i(scan_en),
    .req_valid_i(r2_valid), .req_ready_o(r2_ready), .req_we_i(r2_we),
    .req_addr_i(r2_addr), .req_wdata_i(r2_wdata),
    .rsp_valid_o(r2_rsp_valid), .rsp_ready_i(r2_rsp_ready), .rsp_rdata_o(r2_rdata),
    .busy_o(r2_busy), .CEB(r2_ceb), .WEB(r2_web), .A(r2_a), .D(r2_d), .Q(r2_q)
  );

  // SRAM macro models, 1-cycle read latency
  logic [NB-1:0] mem  [NW];
  logic [NB-1:0] mem2 [NW];
  initial begin
    for (int i = 0; i < int'(NW); i++) begin
      mem[i]  = UNW;
      mem2[i] = NB'(i);
    end
  end
  always @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) mem[A] <= D;
      else      Q <= mem[A];
    end
    if (!r2_ceb) begin
      if (!r2_web) mem2[r2_a] <= r2_d;
      else         r2_q <= mem2[r2_a];
    end
  end

  int vectors = 0;
  int errors  = 0;
  logic [NB-1:0] exp_q  [$];
  logic [NB-1:0] exp2_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NB-1:0] exp_main(input int a);
    if (a == 5)     return 32'hDEAD_BEEF;
    else if (a < 5) return 32'hC0DE_0000 + 32'(a);
    else            return UNW;
  endfunction

  function automatic logic [NB-1:0] exp_d2(input int a);
`ifdef SRAM_INIT_SWEEP_EN
    return (a < 0) ? 32'h1 : 32'h0;
`else
    return 32'(a);
`endif
  endfunction

  // Monitor: every response handshake pops one expectation
  initial forever begin
    @(negedge CLK);
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rsp_data", rsp_rdata, exp_q.pop_front());
    end
    if (r2_rsp_valid && r2_rsp_ready) begin
      chk("rsp2_expected", 32'(exp2_q.size() != 0), 1);
      if (exp2_q.size() != 0) chk("rsp2_data", r2_rdata, exp2_q.pop_front());
    end
  end

  task automatic send(input logic we, input int addr, input logic [NB-1:0] wd, input logic [NB-1:0] exp);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_wdata = wd;
    n = 0;
    forever begin
      @(negedge CLK);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        chk("req_timeout", 32'(req_ready), 1);
        break;
      end
    end
    if (req_ready && !we) exp_q.push_back(exp);
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && (exp_q.size() + exp2_q.size()) != 0; c++) @(posedge CLK);
    #1;
    chk("drain", 32'(exp_q.size() + exp2_q.size()), 0);
  endtask

  task automatic wait_idle(output int n);
    bit done;
    n = 0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge CLK);
      if (busy) n++;
      else      done = 1'b1;
      @(posedge CLK); #1;
`ifdef SRAM_INIT_SWEEP_EN
      scan_en = (n >= 500) && (n < 510);
`endif
    end
    scan_en = 1'b0;
  endtask

  initial begin
    int n, acc;
    bit took;
    RST = 1'b1; scan_en = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    r2_valid = 1'b0; r2_we = 1'b0; r2_addr = '0; r2_wdata = '0; r2_rsp_ready = 1'b1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_ceb", 32'(CEB), 1);
    chk("rst_web", 32'(WEB), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 1);
    @(posedge CLK); #1;
    RST = 1'b0;

    wait_idle(n);
    chk("busy_cycles", 32'(n), 32'(EXP_BUSY));
    rsp_ready = 1'b1;
`ifdef SRAM_INIT_SWEEP_EN
    send(1'b0, 0, '0, 32'h0);
    send(1'b0, 511, '0, 32'h0);
    send(1'b0, 1023, '0, 32'h0);
    drain();
`endif

    // Write then read back with latency check
    req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(5); req_wdata = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("wr_ready", 32'(req_ready), 1);
    chk("wr_ceb", 32'(CEB), 0);
    chk("wr_web", 32'(WEB), 0);
    chk("wr_addr", 32'(A), 5);
    chk("wr_data", D, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    req_we = 1'b0;
    @(negedge CLK);
    chk("rd_ready", 32'(req_ready), 1);
    chk("rd_web", 32'(WEB), 1);
    exp_q.push_back(32'hDEAD_BEEF);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    chk("lat1_rsp_valid", 32'(rsp_valid), 0);
    @(negedge CLK);
    chk("lat2_rsp_valid", 32'(rsp_valid), 1);
    @(posedge CLK); #1;

    for (int i = 0; i < 5; i++) send(1'b1, i, 32'hC0DE_0000 + 32'(i), '0);

    // Backpressure: only RSP_DEPTH reads accepted
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      took = req_ready;
      if (took) begin
        acc++;
        exp_q.push_back(exp_main(int'(req_addr)));
      end
      @(posedge CLK); #1;
      if (took) req_addr = req_addr + AW'(1);
    end
    chk("bp_accepts", 32'(acc), 4);
    @(negedge CLK);
    chk("bp_ready_low", 32'(req_ready), 0);
    @(posedge CLK); #1;
    req_valid = 1'b0;

    // Writes bypass a full FIFO
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(100 + i); req_wdata = 32'h5555_0000 + 32'(i);
      @(negedge CLK);
      chk("full_wr_ready", 32'(req_ready), 1);
      chk("full_wr_ceb", 32'(CEB), 0);
      chk("full_wr_web", 32'(WEB), 0);
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
    chk("full_kept", 32'(exp_q.size()), 4);

    rsp_ready = 1'b1;
    send(1'b0, 4, '0, exp_main(4));
    send(1'b0, 5, '0, exp_main(5));
    drain();

    // Streaming reads at RSP_DEPTH=4: one per cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      took = req_ready;
      if (took) begin
        acc++;
        exp_q.push_back(exp_main(int'(req_addr)));
      end
      @(posedge CLK); #1;
      if (took) req_addr = req_addr + AW'(1);
    end
    req_valid = 1'b0;
    chk("tput4_accepts", 32'(acc), 8);
    drain();

    // Streaming reads at RSP_DEPTH=2: two per three cycles
    r2_valid = 1'b1; r2_addr = AW'(7); acc = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge CLK);
      took = r2_ready;
      if (took) begin
        acc++;
        exp2_q.push_back(exp_d2(int'(r2_addr)));
      end
      chk("tput2_ceb", 32'(r2_ceb), 32'(!took));
      @(posedge CLK); #1;
      if (took) r2_addr = r2_addr + AW'(1);
    end
    r2_valid = 1'b0;
    chk("tput2_accepts", 32'(acc), 6);
    drain();

    // Reset right after a read accept discards the read
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(5);
    @(negedge CLK);
    chk("rstrd_ready", 32'(req_ready), 1);
    @(posedge CLK); #1;
    req_valid = 1'b0; RST = 1'b1;
    @(negedge CLK);
    chk("rstrd_ceb", 32'(CEB), 1);
    chk("rstrd_rsp_valid", 32'(rsp_valid), 0);
    chk("rstrd_req_ready", 32'(req_ready), 0);
    chk("rstrd_busy", 32'(busy), 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("rstrd_no_rsp", 32'(rsp_valid), 0);
    end
    @(posedge CLK); #1;
    wait_idle(n);
    send(1'b0, 5, '0, EXP_RD5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
